// File: rtl/mux4a2_cond_tx.sv
// Transmit-side 4-to-2 lane serializer: four 8-bit lanes captured every other clk_2f edge,
// interleaved onto two output lanes at full clk_2f rate with per-slot valid and data hold.

module mux4a2_cond_pair (
    input  logic       clk_2f,
    input  logic       reset,
    input  logic       capture_i,
    input  logic       valid_a_i,
    input  logic [7:0] data_a_i,
    input  logic       valid_b_i,
    input  logic [7:0] data_b_i,
    output logic       valid_o,
    output logic [7:0] data_o
);

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
    } slot_t;

    slot_t      hold_a_q, hold_a_d;
    slot_t      hold_b_q, hold_b_d;
    slot_t      emit_slot;
    logic       valid_q, valid_d;
    logic [7:0] data_q, data_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        hold_a_d  = hold_a_q;
        hold_b_d  = hold_b_q;
        emit_slot = capture_i ? hold_b_q : hold_a_q;
        if (capture_i) begin
            hold_a_d = {valid_a_i, data_a_i};
            hold_b_d = {valid_b_i, data_b_i};
        end
        valid_d = emit_slot.valid;
        data_d  = emit_slot.valid ? emit_slot.data : data_q;
    end

    // NOTE: non-blocking updates make the B emit on a capture edge see the pre-edge
    // hold_b_q, while the same edge loads the new capture into the holds.
    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            hold_a_q <= '0;
            hold_b_q <= '0;
            valid_q  <= 1'b0;
            data_q   <= 8'h00;
        end else begin
            hold_a_q <= hold_a_d;
            hold_b_q <= hold_b_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

module mux4a2_cond_tx (
    input  logic       clk_2f,
    input  logic       reset,
    input  logic       valid_in0,
    input  logic       valid_in1,
    input  logic       valid_in2,
    input  logic       valid_in3,
    input  logic [7:0] data_in0,
    input  logic [7:0] data_in1,
    input  logic [7:0] data_in2,
    input  logic [7:0] data_in3,
    output logic       validout0,
    output logic       validout1,
    output logic [7:0] dataout0,
    output logic [7:0] dataout1,
    output logic       lane_sel
);

    // Capture edges alternate with A-emit edges; the first edge after reset captures.
    typedef enum logic {
        PH_CAPTURE = 1'b0,
        PH_EMIT_A  = 1'b1
    } phase_t;

    phase_t phase_q, phase_d;
    logic   lane_sel_q, lane_sel_d;
    logic   capture;

    always_comb begin
        phase_d    = PH_CAPTURE;
        lane_sel_d = 1'b0;
        case (phase_q)
            PH_CAPTURE: begin
                phase_d    = PH_EMIT_A;
                lane_sel_d = 1'b1;
            end
            PH_EMIT_A: begin
                phase_d    = PH_CAPTURE;
                lane_sel_d = 1'b0;
            end
            default: begin
                phase_d    = PH_CAPTURE;
                lane_sel_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            phase_q    <= PH_CAPTURE;
            lane_sel_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            lane_sel_q <= lane_sel_d;
        end
    end

    assign capture  = (phase_q == PH_CAPTURE);
    assign lane_sel = lane_sel_q;

    mux4a2_cond_pair u_pair0 (
        .clk_2f    (clk_2f),
        .reset     (reset),
        .capture_i (capture),
        .valid_a_i (valid_in0),
        .data_a_i  (data_in0),
        .valid_b_i (valid_in1),
        .data_b_i  (data_in1),
        .valid_o   (validout0),
        .data_o    (dataout0)
    );

    mux4a2_cond_pair u_pair1 (
        .clk_2f    (clk_2f),
        .reset     (reset),
        .capture_i (capture),
        .valid_a_i (valid_in2),
        .data_a_i  (data_in2),
        .valid_b_i (valid_in3),
        .data_b_i  (data_in3),
        .valid_o   (validout1),
        .data_o    (dataout1)
    );

endmodule

// File: tb/tb_mux4a2_cond_tx.sv
// Directed bench for mux4a2_cond_tx: hand-computed expectations checked after each rising edge.

module tb_mux4a2_cond_tx;

    logic       clk_2f;
    logic       reset;
    logic       valid_in0, valid_in1, valid_in2, valid_in3;
    logic [7:0] data_in0, data_in1, data_in2, data_in3;
    logic       validout0, validout1;
    logic [7:0] dataout0, dataout1;
    logic       lane_sel;

    int n_assert = 0;
    int n_fail   = 0;

    mux4a2_cond_tx dut (
        .clk_2f    (clk_2f),
        .reset     (reset),
        .valid_in0 (valid_in0),
        .valid_in1 (valid_in1),
        .valid_in2 (valid_in2),
        .valid_in3 (valid_in3),
        .data_in0  (data_in0),
        .data_in1  (data_in1),
        .data_in2  (data_in2),
        .data_in3  (data_in3),
        .validout0 (validout0),
        .validout1 (validout1),
        .dataout0  (dataout0),
        .dataout1  (dataout1),
        .lane_sel  (lane_sel)
    );

    initial clk_2f = 1'b0;
    always #5 clk_2f = ~clk_2f;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp_v);
        end
    endtask

    task automatic check_out(input string tag, input logic ev0, input logic [7:0] ed0,
                             input logic ev1, input logic [7:0] ed1, input logic els);
        chk({tag, ".validout0"}, {7'd0, validout0}, {7'd0, ev0});
        chk({tag, ".dataout0"},  dataout0,          ed0);
        chk({tag, ".validout1"}, {7'd0, validout1}, {7'd0, ev1});
        chk({tag, ".dataout1"},  dataout1,          ed1);
        chk({tag, ".lane_sel"},  {7'd0, lane_sel},  {7'd0, els});
    endtask

    task automatic tick();
        @(posedge clk_2f);
        #1;
    endtask

    task automatic set_lanes(input logic [3:0] v, input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [7:0] d3);
        {valid_in3, valid_in2, valid_in1, valid_in0} = v;
        data_in0 = d0;
        data_in1 = d1;
        data_in2 = d2;
        data_in3 = d3;
    endtask

    initial begin
        reset = 1'b1;
        set_lanes(4'b1111, 8'h5A, 8'h5B, 8'h5C, 8'h5D);

        // Reset held through three edges with live inputs.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("reset_hold", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        end
        set_lanes(4'b0000, 8'h5A, 8'h5B, 8'h5C, 8'h5D);
        reset = 1'b0;

        // E1: first edge after release is a capture edge emitting cleared B.
        tick();
        check_out("startup_cap", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        set_lanes(4'b1111, 8'h11, 8'h22, 8'h33, 8'h44);

        // E2: A-emit of an invalid capture; data stays at reset value.
        tick();
        check_out("startup_emit_a", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

        // E3 = capture k of {11,22,33,44}.
        tick();
        check_out("full_cap_k", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        set_lanes(4'b1111, 8'h55, 8'h66, 8'h77, 8'h88);

        tick();
        check_out("full_k1", 1'b1, 8'h11, 1'b1, 8'h33, 1'b0);
        tick();
        check_out("full_k2", 1'b1, 8'h22, 1'b1, 8'h44, 1'b1);
        set_lanes(4'b1001, 8'hAA, 8'hBB, 8'hCC, 8'hDD);
        tick();
        check_out("full_k3", 1'b1, 8'h55, 1'b1, 8'h77, 1'b0);

        // Partial valid: lanes 1 and 2 invalid.
        tick();
        check_out("full_k4", 1'b1, 8'h66, 1'b1, 8'h88, 1'b1);
        tick();
        check_out("partial_a", 1'b1, 8'hAA, 1'b0, 8'h88, 1'b0);
        set_lanes(4'b1111, 8'h01, 8'h02, 8'h03, 8'h04);
        tick();
        check_out("partial_b", 1'b0, 8'hAA, 1'b1, 8'hDD, 1'b1);

        // Data changed only between capture edges must never surface.
        data_in0 = 8'hEE;
        tick();
        check_out("offcap_a", 1'b1, 8'h01, 1'b1, 8'h03, 1'b0);
        set_lanes(4'b1111, 8'h10, 8'h20, 8'h30, 8'h40);
        tick();
        check_out("offcap_b", 1'b1, 8'h02, 1'b1, 8'h04, 1'b1);
        data_in0 = 8'hEE;
        tick();
        check_out("offcap_a2", 1'b1, 8'h10, 1'b1, 8'h30, 1'b0);

        // Idle: all lanes invalid at the next capture onwards.
        set_lanes(4'b0000, 8'h99, 8'h98, 8'h97, 8'h96);
        tick();
        check_out("idle_last_b", 1'b1, 8'h20, 1'b1, 8'h40, 1'b1);
        for (int i = 0; i < 6; i++) begin
            set_lanes(4'b0000, 8'hF0 + 8'(i), 8'hE0 + 8'(i), 8'hD0 + 8'(i), 8'hC0 + 8'(i));
            tick();
            check_out($sformatf("idle_%0d", i), 1'b0, 8'h20, 1'b0, 8'h40, (i % 2) == 1);
        end

        tick();
        check_out("pre_rst_emit_a", 1'b0, 8'h20, 1'b0, 8'h40, 1'b0);
        set_lanes(4'b1111, 8'hC1, 8'hC2, 8'hC3, 8'hC4);
        tick();
        check_out("pre_rst_cap", 1'b0, 8'h20, 1'b0, 8'h40, 1'b1);

        // Reset between capture k and k+1: clears immediately, captured bytes lost.
        #2;
        reset = 1'b1;
        #1;
        check_out("rst_async", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        tick();
        check_out("rst_edge", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        set_lanes(4'b0000, 8'hC1, 8'hC2, 8'hC3, 8'hC4);
        reset = 1'b0;
        tick();
        check_out("post_rst_cap", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        tick();
        check_out("post_rst_a", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        tick();
        check_out("post_rst_b", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
